// File: rtl/three_input_debounce_sync.sv
// Three-channel input conditioner: two-flop synchroniser plus stability-count
// debouncer per channel, with registered one-cycle rise/fall/change strobes.
module three_input_debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] rise,
  output logic [2:0] fall,
  output logic       change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]            meta_q;
  logic [2:0]            sync_q;
  logic [2:0]            level_q;
  logic [2:0]            level_d;
  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;
  logic [2:0]            rise_q;
  logic [2:0]            rise_d;
  logic [2:0]            fall_q;
  logic [2:0]            fall_d;
  logic                  change_q;
  logic                  change_d;

  // Plain two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= raw_in;
      sync_q <= meta_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count from zero.
  always_comb begin
    level_d  = level_q;
    cnt_d    = cnt_q;
    rise_d   = 3'b000;
    fall_d   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = sync_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync_q[i];
        fall_d[i]  = ~sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    change_d = |{rise_d, fall_d};
  end

  // Strobes are registered alongside the level so they coincide with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= 3'b000;
      cnt_q    <= '0;
      rise_q   <= 3'b000;
      fall_q   <= 3'b000;
      change_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign A      = level_q[0];
  assign B      = level_q[1];
  assign C      = level_q[2];
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign change = change_q;

endmodule

// File: tb/tb_three_input_debounce_sync.sv
// Bench for three_input_debounce_sync: default build and a DEBOUNCE_CYCLES=1
// build run side by side against a run-length reference model.
module tb_three_input_debounce_sync;

  logic       clk;
  logic       rst_n;
  logic [2:0] raw0, raw1;
  logic       a0, b0, c0, a1, b1, c1;
  logic [2:0] rise0, fall0, rise1, fall1;
  logic       chg0, chg1;

  int n_assert = 0;
  int n_fail   = 0;

  three_input_debounce_sync #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw0), .A(a0), .B(b0), .C(c0),
    .rise(rise0), .fall(fall0), .change(chg0));

  three_input_debounce_sync #(.DEBOUNCE_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw1), .A(a1), .B(b1), .C(c1),
    .rise(rise1), .fall(fall1), .change(chg1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per unit, raw values seen at the last two edges, the
  // accepted level, and how many consecutive edges the input has disagreed.
  int         dcyc [2] = '{4, 1};
  logic [2:0] h1 [2];
  logic [2:0] h2 [2];
  logic [2:0] mq [2];
  logic [2:0] mrise [2];
  logic [2:0] mfall [2];
  int         run [2][3];

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      h1[u] = 3'b000; h2[u] = 3'b000; mq[u] = 3'b000;
      mrise[u] = 3'b000; mfall[u] = 3'b000;
      for (int c = 0; c < 3; c++) run[u][c] = 0;
    end
  endtask

  task automatic model_edge(input int u, input logic [2:0] r);
    logic [2:0] s;
    s = h2[u];
    mrise[u] = 3'b000;
    mfall[u] = 3'b000;
    for (int c = 0; c < 3; c++) begin
      if (s[c] != mq[u][c]) begin
        run[u][c] = run[u][c] + 1;
        if (run[u][c] == dcyc[u]) begin
          mq[u][c] = s[c];
          if (s[c]) mrise[u][c] = 1'b1;
          else      mfall[u][c] = 1'b1;
          run[u][c] = 0;
        end
      end else begin
        run[u][c] = 0;
      end
    end
    h2[u] = h1[u];
    h1[u] = r;
  endtask

  task automatic chk(input string name, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    chk({tag, "_lvl0"},  {c0, b0, a0}, mq[0]);
    chk({tag, "_rise0"}, rise0, mrise[0]);
    chk({tag, "_fall0"}, fall0, mfall[0]);
    chk({tag, "_chg0"},  {2'b00, chg0}, {2'b00, |{mrise[0], mfall[0]}});
    chk({tag, "_lvl1"},  {c1, b1, a1}, mq[1]);
    chk({tag, "_rise1"}, rise1, mrise[1]);
    chk({tag, "_fall1"}, fall1, mfall[1]);
    chk({tag, "_chg1"},  {2'b00, chg1}, {2'b00, |{mrise[1], mfall[1]}});
  endtask

  task automatic step(input logic [2:0] r0, input logic [2:0] r1, input string tag);
    raw0 = r0;
    raw1 = r1;
    @(posedge clk);
    model_edge(0, r0);
    model_edge(1, r1);
    #1;
    check(tag);
  endtask

  // Assert reset away from a clock edge, check outputs clear at once, release.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_lvl"}, {c0, b0, a0, 1'b0} != 4'b0000 ? 3'b111 : 3'b000, 3'b000);
    chk({tag, "_async_str"}, {rise0 | fall0 | rise1 | fall1}, 3'b000);
    chk({tag, "_async_misc"}, {chg0, chg1, |{c1, b1, a1}}, 3'b000);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] r0, r1;
    logic       t;
    rst_n = 1'b0;
    raw0  = 3'b000;
    raw1  = 3'b000;
    model_clear();
    apply_reset("init");

    // Idle with all inputs low.
    for (int i = 0; i < 8; i++) step(3'b000, 3'b000, "idle");

    // Single channel rise: A must appear at edge 6, not before.
    for (int i = 1; i <= 10; i++) begin
      step(3'b001, 3'b000, "a_rise");
      if (i == 5) chk("a_rise_e5", {2'b00, a0}, 3'b000);
      if (i == 6) begin
        chk("a_rise_e6_lvl", {2'b00, a0}, 3'b001);
        chk("a_rise_e6_str", rise0, 3'b001);
      end
      if (i == 7) chk("a_rise_e7_str", rise0, 3'b000);
    end

    // Short glitch on B is rejected, longer pulse is accepted, then falls.
    for (int i = 0; i < 3; i++)  step(3'b011, 3'b000, "b_glitch");
    for (int i = 0; i < 8; i++)  step(3'b001, 3'b000, "b_quiet");
    for (int i = 0; i < 5; i++)  step(3'b011, 3'b000, "b_pulse");
    for (int i = 0; i < 10; i++) step(3'b001, 3'b000, "b_fall");

    // All three channels together.
    apply_reset("r2");
    for (int i = 1; i <= 10; i++) begin
      step(3'b111, 3'b111, "all_rise");
      if (i == 6) chk("all_rise_e6", rise0, 3'b111);
    end

    // Reset in the middle of a C count, then count again from scratch.
    apply_reset("r3");
    for (int i = 0; i < 4; i++) step(3'b100, 3'b000, "c_partial");
    apply_reset("r_mid");
    for (int i = 1; i <= 9; i++) begin
      step(3'b100, 3'b000, "c_after_rst");
      if (i == 5) chk("c_after_rst_e5", {2'b00, c0}, 3'b000);
      if (i == 6) chk("c_after_rst_e6", rise0, 3'b100);
    end

    // Single-cycle build: toggle channel A every three cycles.
    for (int i = 0; i < 30; i++) begin
      t = 1'((i / 3) % 2);
      step(3'b100, {2'b00, t}, "d1_toggle");
    end

    // Random stimulus with sticky bits so both short and long runs occur.
    r0 = 3'b000;
    r1 = 3'b000;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 3) == 0) r0[c] = ~r0[c];
        if ($urandom_range(0, 2) == 0) r1[c] = ~r1[c];
      end
      step(r0, r1, "rand");
      if (i == 300) apply_reset("r_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
